// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the ALU sequencer: state encoding, ALU opcodes
// and the multiply step-counter width.
package alu_seq_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned StepW = $clog2(DataW);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StSingle,
    StMulStep,
    StDone
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command and response handshake bundle between a requester (master) and the
// ALU sequencer (slave).
interface alu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_cout;
  logic             res_v;
  logic             res_lt;
  logic             res_eq;
  logic             res_gt;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_lo, res_hi, res_cout, res_v, res_lt, res_eq, res_gt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_lo, res_hi, res_cout, res_v, res_lt, res_eq, res_gt
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer driving the shared external ALU: single-pass ops or a shift-add multiply.
// Optional busy-cycle counter enabled by defining ALU_SEQ_BUSY_CNT_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DataW,
  parameter logic [3:0]  MUL_OP = OP_MUL
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
`ifdef ALU_SEQ_BUSY_CNT_EN
  output logic [31:0]      busy_cycles,
`endif
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_v,
  input  logic             alu_lt,
  input  logic             alu_eq,
  input  logic             alu_gt
);

  state_e             state_q, state_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  // Flag order: {cout, v, lt, eq, gt}
  logic [4:0]         flags_q, flags_d;
  logic [2*WIDTH-1:0] shifted;

  // The 33-bit {cout, sum, lo} shifted right by one keeps the add's carry.
  assign shifted = {alu_cout, alu_out, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    op_d     = op_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    alu_x    = '0;
    alu_y    = '0;
    alu_cin  = 1'b0;
    alu_op   = 4'b0000;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          mcand_d = bus.cmd_a;
          lo_d    = bus.cmd_b;
          op_d    = bus.cmd_op;
          hi_d    = '0;
          step_d  = '0;
          state_d = (bus.cmd_op == MUL_OP) ? StMulStep : StSingle;
        end
      end

      StSingle: begin
        // Operand A rides in mcand_q and operand B in lo_q.
        alu_x    = mcand_q;
        alu_y    = lo_q;
        alu_op   = op_q;
        res_lo_d = alu_out;
        res_hi_d = '0;
        flags_d  = {alu_cout, alu_v, alu_lt, alu_eq, alu_gt};
        state_d  = StDone;
      end

      StMulStep: begin
        alu_op = OP_ADD;
        alu_x  = hi_q;
        alu_y  = lo_q[0] ? mcand_q : '0;
        {hi_d, lo_d} = shifted;
        step_d = step_q + 1'b1;
        if (step_q == StepW'(WIDTH - 1)) begin
          res_hi_d = shifted[2*WIDTH-1:WIDTH];
          res_lo_d = shifted[WIDTH-1:0];
          flags_d  = '0;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      op_q     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      op_q     <= op_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.res_valid = (state_q == StDone);
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_cout  = flags_q[4];
  assign bus.res_v     = flags_q[3];
  assign bus.res_lt    = flags_q[2];
  assign bus.res_eq    = flags_q[1];
  assign bus.res_gt    = flags_q[0];

`ifdef ALU_SEQ_BUSY_CNT_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (state_q != StIdle && busy_q != 32'hFFFF_FFFF) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural model of the external ALU.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_cin, alu_cout, alu_v, alu_lt, alu_eq, alu_gt;
  logic [3:0]  alu_op;
`ifdef ALU_SEQ_BUSY_CNT_EN
  logic [31:0] busy_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  alu_seq_ctrl_if #(.WIDTH(16)) bus ();

  alu_seq_ctrl #(.WIDTH(16), .MUL_OP(4'b1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_cin    (alu_cin),
    .alu_op     (alu_op),
`ifdef ALU_SEQ_BUSY_CNT_EN
    .busy_cycles(busy_cycles),
`endif
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_v      (alu_v),
    .alu_lt     (alu_lt),
    .alu_eq     (alu_eq),
    .alu_gt     (alu_gt)
  );

  always #5 clk = ~clk;

  // External ALU model; unknown opcodes return x^y so forwarding is observable.
  always_comb begin
    logic [16:0] s;
    s        = '0;
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_op)
      OP_AND: alu_out = alu_x & alu_y;
      OP_OR:  alu_out = alu_x | alu_y;
      OP_ADD: begin
        s        = {1'b0, alu_x} + {1'b0, alu_y} + {16'd0, alu_cin};
        alu_out  = s[15:0];
        alu_cout = s[16];
        alu_v    = (alu_x[15] == alu_y[15]) && (s[15] != alu_x[15]);
      end
      OP_SUB: begin
        s        = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
        alu_out  = s[15:0];
        alu_cout = s[16];
        alu_v    = (alu_x[15] != alu_y[15]) && (s[15] != alu_x[15]);
      end
      OP_SLT: alu_out = ($signed(alu_x) < $signed(alu_y)) ? 16'd1 : 16'd0;
      default: alu_out = alu_x ^ alu_y;
    endcase
    alu_lt = $signed(alu_x) < $signed(alu_y);
    alu_eq = alu_x == alu_y;
    alu_gt = $signed(alu_x) > $signed(alu_y);
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [4:0]  fl;   // {cout, v, lt, eq, gt}
    logic [7:0]  lat;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] res_flags();
    return {bus.res_cout, bus.res_v, bus.res_lt, bus.res_eq, bus.res_gt};
  endfunction

  // Issue one command; returns edges from accept (edge 1) until res_valid is seen.
  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
    logic bad_rdy, bad_alu;
    bad_rdy = 1'b0;
    bad_alu = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 16'hDEAD;
    bus.cmd_b     = 16'hBEEF;
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 100) begin
      if (bus.cmd_ready !== 1'b0) bad_rdy = 1'b1;
      if (op == OP_MUL) begin
        if (alu_op !== OP_ADD || alu_cin !== 1'b0) bad_alu = 1'b1;
      end else if (alu_op !== op || alu_x !== a || alu_y !== b || alu_cin !== 1'b0) begin
        bad_alu = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_not_ready", {31'd0, bad_rdy}, 32'd0);
    chk("alu_drive", {31'd0, bad_alu}, 32'd0);
    chk("done_not_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("done_alu_op", {28'd0, alu_op}, 32'd0);
  endtask

  task automatic release_res();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    chk("post_valid_low", {31'd0, bus.res_valid}, 32'd0);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        bad;
    logic [15:0] keep_lo;

    vecs[0]  = '{OP_ADD, 16'h0005, 16'h0005, 16'h000A, 16'h0000, 5'b00010, 8'd2};
    vecs[1]  = '{OP_SUB, 16'h0003, 16'h0008, 16'hFFFB, 16'h0000, 5'b00100, 8'd2};
    vecs[2]  = '{OP_AND, 16'h000B, 16'h0009, 16'h0009, 16'h0000, 5'b00001, 8'd2};
    vecs[3]  = '{OP_OR,  16'h00F0, 16'h0F0F, 16'h0FFF, 16'h0000, 5'b00100, 8'd2};
    vecs[4]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b01001, 8'd2};
    vecs[5]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10100, 8'd2};
    vecs[6]  = '{OP_SLT, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 5'b00100, 8'd2};
    vecs[7]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 5'b10010, 8'd2};
    vecs[8]  = '{4'hF,   16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 5'b00100, 8'd2};
    vecs[9]  = '{OP_MUL, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 5'b00000, 8'd17};
    vecs[10] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00000, 8'd17};
    vecs[11] = '{OP_MUL, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 5'b00000, 8'd17};
    vecs[12] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 5'b00000, 8'd17};
    vecs[13] = '{OP_MUL, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 5'b00000, 8'd17};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 16'd0;
    bus.cmd_b     = 16'd0;
    bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res", {bus.res_hi, bus.res_lo}, 32'd0);
    chk("rst_flags", {27'd0, res_flags()}, 32'd0);
    chk("rst_alu", {alu_x, alu_y}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op, alu_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, {24'd0, vecs[i].lat});
      chk($sformatf("v%0d_product", i), {bus.res_hi, bus.res_lo}, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("v%0d_flags", i), {27'd0, res_flags()}, {27'd0, vecs[i].fl});
      release_res();
    end

    // Back-pressure: result must hold while res_ready stays low.
    run_cmd(OP_OR, 16'h1200, 16'h0034, lat);
    keep_lo = bus.res_lo;
    chk("stall_lo", {16'd0, keep_lo}, 32'h0000_1234);
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_lo !== 16'h1234 || bus.res_hi !== 16'h0
          || bus.cmd_ready !== 1'b0) bad = 1'b1;
    end
    chk("stall_stable", {31'd0, bad}, 32'd0);
    release_res();

    // Asynchronous reset in the middle of a multiply (step 8).
    @(negedge clk);
    bus.cmd_op    = OP_MUL;
    bus.cmd_a     = 16'h00FF;
    bus.cmd_b     = 16'h00FF;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("arst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("arst_res", {bus.res_hi, bus.res_lo}, 32'd0);
    chk("arst_alu", {alu_x, alu_y}, 32'd0);
    chk("arst_alu_op", {28'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) bad = 1'b1;
    end
    chk("arst_no_response", {31'd0, bad}, 32'd0);

    run_cmd(OP_MUL, 16'h0003, 16'h0007, lat);
    chk("mul_after_rst_lat", lat, 32'd17);
    chk("mul_after_rst", {bus.res_hi, bus.res_lo}, 32'h0000_0015);
    release_res();

`ifdef ALU_SEQ_BUSY_CNT_EN
    do_reset();
    #1;
    chk("busy_rst", busy_cycles, 32'd0);
    run_cmd(OP_ADD, 16'h0001, 16'h0002, lat);
    release_res();
    repeat (3) @(negedge clk);
    run_cmd(OP_MUL, 16'h0002, 16'h0003, lat);
    release_res();
    repeat (3) @(negedge clk);
    chk("busy_count", busy_cycles, 32'd19);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
